// File: rtl/qdr_user_sequencer_if.sv
// Request, response and controller user-port bundle for qdr_user_sequencer.
// Handshake rule for wr_* and rd_*: a transfer happens on a rising clk0 edge
// where valid & ready are both 1. Ready may depend on valid in the same
// cycle. rsp_valid is a single-cycle strobe with no backpressure.
// master = client plus controller side, slave = the sequencer.
`timescale 1ns/1ps
interface qdr_user_sequencer_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 36,
  parameter int BE_WIDTH   = 4,
  parameter int TAG_WIDTH  = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_be;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [TAG_WIDTH-1:0]  rd_tag;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic [ADDR_WIDTH-1:0] usr_addr;
  logic                  usr_wr_strb;
  logic [DATA_WIDTH-1:0] usr_wr_data;
  logic [BE_WIDTH-1:0]   usr_wr_be;
  logic                  usr_rd_strb;
  logic [DATA_WIDTH-1:0] usr_rd_data;
  logic                  usr_rd_dvld;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be,
    output rd_valid, rd_addr, rd_tag,
    input  wr_ready, rd_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    input  usr_addr, usr_wr_strb, usr_wr_data, usr_wr_be, usr_rd_strb,
    output usr_rd_data, usr_rd_dvld
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be,
    input  rd_valid, rd_addr, rd_tag,
    output wr_ready, rd_ready,
    output rsp_valid, rsp_data, rsp_tag,
    output usr_addr, usr_wr_strb, usr_wr_data, usr_wr_be, usr_rd_strb,
    input  usr_rd_data, usr_rd_dvld
  );
endinterface

// File: rtl/qdr_user_sequencer.sv
// Round-robin write/read sequencer in front of the QDR controller user port.
// Gates issue on calibration, tracks outstanding reads with a tag FIFO and
// returns each read response with the tag of the request that produced it.
`timescale 1ns/1ps
module qdr_user_sequencer #(
  parameter int ADDR_WIDTH      = 22,
  parameter int DATA_WIDTH      = 36,
  parameter int BE_WIDTH        = 4,
  parameter int TAG_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int RD_TIMEOUT      = 1023
) (
  input  logic                                   clk0,
  input  logic                                   reset,
  input  logic                                   phy_rdy,
  input  logic                                   cal_fail,
  qdr_user_sequencer_if.slave                    bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   rd_timeout,
  output logic                                   rd_err,
  output logic                                   fail,
  output logic [1:0]                             state_dbg
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] TMO_MAX = CW'(RD_TIMEOUT);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  run;
  logic                  prio_rd;
  logic                  rd_req;
  logic                  contest;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  dvld_ok;
  logic [TAG_WIDTH-1:0]  tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         tag_wr_ptr;
  logic [PW-1:0]         tag_rd_ptr;
  logic [CW-1:0]         tmo_cnt;

  // State register.
  always_ff @(posedge clk0) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Next state: cal_fail wins from any state; FAIL is only left by reset.
  always_comb begin
    state_d = state_q;
    if (cal_fail) begin
      state_d = ST_FAIL;
    end else begin
      case (state_q)
        ST_INIT: if (phy_rdy)  state_d = ST_RUN;
        ST_RUN:  if (!phy_rdy) state_d = ST_INIT;
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_INIT;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    run       = (state_q == ST_RUN);
    fail      = (state_q == ST_FAIL);
    state_dbg = state_q;
  end

  // Arbitration: a read only competes when a tag slot is free, so a full
  // read side never blocks a pending write. Ties go to the loser of the
  // last contest.
  always_comb begin
    rd_req       = bus.rd_valid && (outstanding < OUT_MAX);
    contest      = bus.wr_valid && rd_req;
    wr_acc       = run && bus.wr_valid && (!rd_req || !prio_rd);
    rd_acc       = run && rd_req && (!bus.wr_valid || prio_rd);
    bus.wr_ready = wr_acc;
    bus.rd_ready = rd_acc;
    dvld_ok      = bus.usr_rd_dvld && (outstanding != '0);
  end

  // Round-robin pointer: after a contest the other requester is favoured.
  always_ff @(posedge clk0) begin
    if (reset)        prio_rd <= 1'b0;
    else if (contest && run) prio_rd <= wr_acc;
  end

  // Issue register: one-cycle strobes; address/data/be hold between issues.
  always_ff @(posedge clk0) begin
    if (reset) begin
      bus.usr_wr_strb <= 1'b0;
      bus.usr_rd_strb <= 1'b0;
      bus.usr_addr    <= '0;
      bus.usr_wr_data <= '0;
      bus.usr_wr_be   <= '0;
    end else begin
      bus.usr_wr_strb <= wr_acc;
      bus.usr_rd_strb <= rd_acc;
      if (wr_acc) begin
        bus.usr_addr    <= bus.wr_addr;
        bus.usr_wr_data <= bus.wr_data;
        bus.usr_wr_be   <= bus.wr_be;
      end else if (rd_acc) begin
        bus.usr_addr <= bus.rd_addr;
      end
    end
  end

  // Tag FIFO: pushed on read accept, popped by each counted return.
  always_ff @(posedge clk0) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= '0;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else begin
      if (rd_acc) begin
        tag_mem[tag_wr_ptr] <= bus.rd_tag;
        tag_wr_ptr          <= tag_wr_ptr + 1'b1;
      end
      if (dvld_ok) tag_rd_ptr <= tag_rd_ptr + 1'b1;
    end
  end

  // Outstanding read count; simultaneous accept and return cancel.
  always_ff @(posedge clk0) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_acc, dvld_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Registered read response carrying the FIFO head tag.
  always_ff @(posedge clk0) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_tag   <= '0;
    end else begin
      bus.rsp_valid <= dvld_ok;
      if (dvld_ok) begin
        bus.rsp_data <= bus.usr_rd_data;
        bus.rsp_tag  <= tag_mem[tag_rd_ptr];
      end
    end
  end

  // Sticky error flags and the saturating read-return watchdog.
  always_ff @(posedge clk0) begin
    if (reset) begin
      tmo_cnt    <= '0;
      rd_timeout <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      if (bus.usr_rd_dvld || (outstanding == '0)) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)               tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_cnt == TMO_MAX) rd_timeout <= 1'b1;
      if (bus.usr_rd_dvld && (outstanding == '0)) rd_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qdr_user_sequencer.sv
// Directed bench for qdr_user_sequencer with queue-based scoreboard.
`timescale 1ns/1ps
module tb_qdr_user_sequencer;
  localparam int AW = 22;
  localparam int DW = 36;
  localparam int BW = 4;
  localparam int TW = 4;
  localparam int MO = 16;
  localparam int RT = 1023;
  localparam int OW = $clog2(MO + 1);
  localparam int ISS_W = 1 + AW + DW + BW;
  localparam int RSP_W = TW + DW;

  logic          clk0 = 1'b0;
  logic          reset;
  logic          phy_rdy;
  logic          cal_fail;
  logic [OW-1:0] outstanding;
  logic          rd_timeout;
  logic          rd_err;
  logic          fail;
  logic [1:0]    state_dbg;

  qdr_user_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_WIDTH(TW)) bus ();

  qdr_user_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_WIDTH(TW),
    .MAX_OUTSTANDING(MO), .RD_TIMEOUT(RT)
  ) dut (
    .clk0(clk0), .reset(reset), .phy_rdy(phy_rdy), .cal_fail(cal_fail),
    .bus(bus), .outstanding(outstanding), .rd_timeout(rd_timeout),
    .rd_err(rd_err), .fail(fail), .state_dbg(state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk0 = ~clk0;
  int cyc = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  // Scoreboard state.
  logic [ISS_W-1:0] iss_q[$];
  int               iss_cyc_q[$];
  logic [RSP_W-1:0] rsp_q[$];
  int               rsp_cyc_q[$];
  logic [TW-1:0]    tag_mdl[$];
  logic [DW-1:0]    last_wd;
  logic [BW-1:0]    last_be;
  logic [ISS_W-1:0] mon_iss;
  logic [RSP_W-1:0] mon_rsp;
  int               mon_cyc;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an issue or response.
  always @(negedge clk0) begin
    if (!reset) begin
      if (bus.usr_wr_strb || bus.usr_rd_strb) begin
        if (iss_q.size() == 0) begin
          check("unexpected_issue", {bus.usr_wr_strb, bus.usr_rd_strb}, 64'd0);
        end else begin
          mon_iss = iss_q.pop_front();
          mon_cyc = iss_cyc_q.pop_front();
          check("issue_payload", {bus.usr_rd_strb, bus.usr_addr, bus.usr_wr_data, bus.usr_wr_be}, mon_iss);
          check("issue_cycle", cyc, mon_cyc);
          check("issue_one_strobe", bus.usr_wr_strb & bus.usr_rd_strb, 64'd0);
        end
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", bus.rsp_valid, 64'd0);
        end else begin
          mon_rsp = rsp_q.pop_front();
          mon_cyc = rsp_cyc_q.pop_front();
          check("rsp_tag_data", {bus.rsp_tag, bus.rsp_data}, mon_rsp);
          check("rsp_cycle", cyc, mon_cyc);
        end
      end
    end
  end

  // Driver: presents one cycle of stimulus and records expected outcomes.
  task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [BW-1:0] wb, input bit rv, input logic [AW-1:0] ra,
                      input logic [TW-1:0] rt, input bit dv, input logic [DW-1:0] dd,
                      output bit w_acc, output bit r_acc);
    bus.wr_valid = wv;  bus.wr_addr = wa;  bus.wr_data = wd;  bus.wr_be = wb;
    bus.rd_valid = rv;  bus.rd_addr = ra;  bus.rd_tag = rt;
    bus.usr_rd_dvld = dv;  bus.usr_rd_data = dd;
    @(negedge clk0);
    w_acc = wv && bus.wr_ready;
    r_acc = rv && bus.rd_ready;
    if (wv && rv) check("single_accept", {63'd0, w_acc & r_acc}, 64'd0);
    if (dv && tag_mdl.size() > 0) begin
      rsp_q.push_back({tag_mdl.pop_front(), dd});
      rsp_cyc_q.push_back(cyc + 1);
    end
    if (w_acc) begin
      iss_q.push_back({1'b0, wa, wd, wb});
      iss_cyc_q.push_back(cyc + 1);
      last_wd = wd;
      last_be = wb;
    end
    if (r_acc) begin
      iss_q.push_back({1'b1, ra, last_wd, last_be});
      iss_cyc_q.push_back(cyc + 1);
      tag_mdl.push_back(rt);
    end
    @(posedge clk0);
    #1;
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    bus.usr_rd_dvld = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b, output bit acc);
    bit r;
    step(1'b1, a, d, b, 1'b0, '0, '0, 1'b0, '0, acc, r);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [TW-1:0] t, output bit acc);
    bit w;
    step(1'b0, '0, '0, '0, 1'b1, a, t, 1'b0, '0, w, acc);
  endtask

  task automatic dvld(input logic [DW-1:0] d);
    bit w, r;
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b1, d, w, r);
  endtask

  task automatic idle(input int n);
    bit w, r;
    repeat (n) step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, w, r);
  endtask

  task automatic do_reset();
    check("queues_empty_before_reset", 64'(iss_q.size() + rsp_q.size()), 64'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk0);
    #1;
    reset = 1'b0;
    tag_mdl.delete();
    last_wd = '0;
    last_be = '0;
  endtask

  // Watchdog bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Directed sequence.
  initial begin
    bit wa, ra;
    reset = 1'b1;  phy_rdy = 1'b0;  cal_fail = 1'b0;
    bus.wr_valid = 1'b0;  bus.wr_addr = '0;  bus.wr_data = '0;  bus.wr_be = '0;
    bus.rd_valid = 1'b0;  bus.rd_addr = '0;  bus.rd_tag = '0;
    bus.usr_rd_dvld = 1'b0;  bus.usr_rd_data = '0;
    last_wd = '0;  last_be = '0;
    repeat (3) @(posedge clk0);
    #1;
    reset = 1'b0;

    // Reset state.
    check("rst_state", state_dbg, 64'd0);
    check("rst_outstanding", outstanding, 64'd0);
    check("rst_flags", {fail, rd_err, rd_timeout}, 64'd0);
    check("rst_strobes", {bus.usr_wr_strb, bus.usr_rd_strb, bus.rsp_valid}, 64'd0);
    check("rst_usr_addr", bus.usr_addr, 64'd0);

    // No issue before calibration; write issues once RUN is reached.
    for (int i = 0; i < 3; i++) begin
      wr(22'h000010, 36'h0_1234_5678, 4'hF, wa);
      check("init_wr_ready", wa, 64'd0);
    end
    phy_rdy = 1'b1;
    wr(22'h000010, 36'h0_1234_5678, 4'hF, wa);
    check("wr_ready_still_init", wa, 64'd0);
    wr(22'h000010, 36'h0_1234_5678, 4'hF, wa);
    check("wr_ready_run", wa, 64'd1);
    idle(2);
    check("state_run", state_dbg, 64'd1);

    // Both requesters held for 6 cycles: W,R,W,R,W,R back to back.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, AW'(22'h100 + k), DW'(36'h1_0000_0000 + k), 4'h3,
           1'b1, AW'(22'h200 + k), TW'(k), 1'b0, '0, wa, ra);
      check("alt_wr_ready", wa, (k % 2 == 0) ? 64'd1 : 64'd0);
      check("alt_rd_ready", ra, (k % 2 == 1) ? 64'd1 : 64'd0);
    end
    idle(1);
    check("alt_outstanding", outstanding, 64'd3);
    for (int i = 0; i < 3; i++) dvld(DW'(36'h0_CAFE_0000 + i));
    idle(2);
    check("alt_drained", outstanding, 64'd0);

    // Fill all 16 tag slots, then the 17th read is refused.
    for (int i = 0; i < 16; i++) begin
      rd(AW'(22'h3000 + i), TW'(i), ra);
      check("fill_rd_ready", ra, 64'd1);
    end
    check("full_outstanding", outstanding, 64'd16);
    rd(22'h3FFF, 4'hE, ra);
    check("full_rd_ready", ra, 64'd0);

    // Full with read attempt and return in one cycle: no accept, count drops.
    step(1'b0, '0, '0, '0, 1'b1, 22'h3FFF, 4'hE, 1'b1, 36'hA_0000_0000, wa, ra);
    check("full_dvld_rd_ready", ra, 64'd0);
    check("full_dvld_outstanding", outstanding, 64'd15);
    for (int i = 1; i <= 10; i++) dvld(DW'(36'hA_0000_0000 + i));
    check("mid_outstanding", outstanding, 64'd5);
    step(1'b0, '0, '0, '0, 1'b1, 22'h3100, 4'hC, 1'b1, 36'hA_0000_000B, wa, ra);
    check("mid_accept_dvld_rd_ready", ra, 64'd1);
    check("mid_accept_dvld_outstanding", outstanding, 64'd5);
    for (int i = 12; i <= 16; i++) dvld(DW'(36'hA_0000_0000 + i));
    idle(2);
    check("fill_drained", outstanding, 64'd0);

    // Read never returned: watchdog flag after RD_TIMEOUT cycles, sticky.
    rd(22'h0AAA, 4'h3, ra);
    check("tmo_rd_ready", ra, 64'd1);
    repeat (1000) @(posedge clk0);
    #1;
    check("tmo_not_yet", rd_timeout, 64'd0);
    repeat (30) @(posedge clk0);
    #1;
    check("tmo_set", rd_timeout, 64'd1);
    dvld(36'h0_DEAD_BEEF);
    idle(2);
    check("tmo_sticky", rd_timeout, 64'd1);
    check("tmo_outstanding", outstanding, 64'd0);
    check("tmo_no_rd_err", rd_err, 64'd0);

    // Lone return after reset is spurious.
    do_reset();
    check("rst2_timeout_clear", rd_timeout, 64'd0);
    dvld(36'h1_1111_1111);
    check("spurious_rd_err", rd_err, 64'd1);
    check("spurious_rsp_valid", bus.rsp_valid, 64'd0);
    check("spurious_outstanding", outstanding, 64'd0);

    // Calibration failure mid-traffic: readies drop, in-flight read returns.
    idle(1);
    check("pre_fail", fail, 64'd0);
    rd(22'h0555, 4'h5, ra);
    check("fail_pre_rd_ready", ra, 64'd1);
    cal_fail = 1'b1;
    idle(1);
    cal_fail = 1'b0;
    check("fail_set", fail, 64'd1);
    wr(22'h0777, 36'h7_7777_7777, 4'h1, wa);
    check("fail_wr_ready", wa, 64'd0);
    rd(22'h0778, 4'h6, ra);
    check("fail_rd_ready", ra, 64'd0);
    dvld(36'h5_5555_5555);
    idle(2);
    check("fail_drained", outstanding, 64'd0);
    check("fail_sticky", fail, 64'd1);
    check("fail_state", state_dbg, 64'd2);

    // Final report.
    idle(2);
    check("iss_q_empty", 64'(iss_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
